clk_divider_prog: RTL
=====================

Name: clk_divider_prog

Overview:
- Multi-channel, runtime-programmable clock divider.
- Generalises the fixed divide-by-250 oscillator divider into NUM_CH independent channels, each with its own full-period divide ratio.
- Ratio updates are glitch-free: applied only at period boundaries. Per-channel enable and a global phase-sync are provided.
- Sits between the system oscillator and the encoder/decoder timing logic; also produces one-cycle TICK strobes for logic kept on INPUT_CLK.

Parameters:
- NUM_CH, 2: number of independent output channels (1..8).
- CNT_W, 16: width of the divide ratio and internal counters.
- DEFAULT_DIV, 250: ratio loaded into every channel at reset (must be ≥2 and <2^CNT_W).

Ports:
- INPUT_CLK  in  1  source clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  NUM_CH  per-channel run enable.
- SYNC  in  1  single-cycle pulse; restarts all enabled channels phase-aligned.
- CFG_VALID  in  1  configuration request.
- CFG_READY  out  1  configuration can be accepted.
- CFG_CH  in  max(1,$clog2(NUM_CH))  target channel.
- CFG_DIV  in  CNT_W  requested full-period ratio N.
- CFG_ERR  out  1  one-cycle pulse: request rejected.
- OUTPUT_CLK  out  NUM_CH  divided clocks (registered).
- TICK  out  NUM_CH  one-cycle pulse coincident with each OUTPUT_CLK rising transition.

Behaviour:
- Reset (RST_N low, asynchronous):
  - OUTPUT_CLK=0, TICK=0, CFG_ERR=0.
  - All channels in IDLE; active and shadow ratios = DEFAULT_DIV; pending flags cleared.
  - CFG_READY=1 from the first cycle after release.
- Period split for ratio N: high phase H=N>>1, low phase L=N-H. Odd N gives the extra cycle to low.
  - Example: N=5 gives 2 high, 3 low.
- Per-channel FSM, states IDLE/HIGH/LOW; down-counter cnt[CNT_W-1:0]:
  - IDLE: OUTPUT_CLK=0. If EN[i]=1 at an edge: go HIGH, OUTPUT_CLK<=1, TICK<=1, cnt<=H-1.
  - HIGH: cnt!=0 → decrement. cnt==0 → go LOW, OUTPUT_CLK<=0, cnt<=L-1.
  - LOW: cnt!=0 → decrement. cnt==0 is the period boundary:
    - If pending, active<=shadow and clear pending.
    - If EN[i]=1: go HIGH with the new H, TICK pulse.
    - Otherwise go IDLE.
  - From IDLE enable to first TICK: one edge. Output period is exactly N cycles.
- EN deassert mid-period: the current period completes (no runt pulse); the channel stops at the next boundary.
- Config handshake: transfer when CFG_VALID && CFG_READY.
  - CFG_READY = !pending[CFG_CH]. Combinational on CFG_CH only, not on CFG_VALID.
  - Accepted: shadow[CFG_CH]<=CFG_DIV, pending<=1.
  - A channel in IDLE applies the pending ratio on the next edge.
  - Rejected when CFG_DIV<2 or CFG_CH≥NUM_CH: shadow untouched, CFG_ERR pulses the next cycle. A rejected transfer still counts as a handshake.
- SYNC pulse: every channel with EN=1 applies any pending ratio, goes HIGH with cnt<=H-1 and OUTPUT_CLK<=1, and TICK pulses, all on the same edge.
  - Truncating a period on SYNC is permitted (documented exception to glitch-free).
  - Channels with EN=0 are unaffected.
- Simultaneous events:
  - Config accepted in the same cycle as SYNC: the newly accepted ratio is applied by that SYNC.
  - Config accepted on a channel's boundary cycle: not applied until the following boundary.
  - SYNC on a boundary cycle: identical result to the boundary (single TICK).
- N=2: H=1, L=1, so OUTPUT_CLK toggles every cycle.
- N=2^CNT_W-1 must work without counter overflow.
- Reset mid-operation: immediate return to reset values, including pending updates discarded.

Test Plan:
- Reset with DEFAULT_DIV=250, EN=2'b01 → ch0 TICK every 250 cycles, 125 high/125 low; ch1 OUTPUT_CLK stays 0, CFG_READY=1.
- Write ch0 CFG_DIV=5 mid-high-phase of a 250 period → current 250 period completes unaltered; from the next boundary, period 5 with 2 high/3 low. CFG_READY for ch0 is low from accept until that boundary.
- Write CFG_DIV=1, then CFG_DIV=0 → CFG_ERR pulse each, ratio unchanged, no READY stall.
- Ch0 N=6, ch1 N=9, both enabled, asynchronous start, then pulse SYNC → both OUTPUT_CLK rise on the edge after SYNC with TICK=2'b11; rising edges thereafter coincide every 18 cycles.
- Drop EN[0] one cycle into high phase with N=10 → 5 high + 5 low complete, then IDLE with output 0 and no further TICK.
- Assert RST_N low during a pending write and the high phase → outputs 0 asynchronously. After release, enable gives a period of DEFAULT_DIV (pending discarded).

Source files
------------

// File: rtl/clk_divider_prog_if.sv
// Configuration handshake bundle for clk_divider_prog.
// The master requests a ratio change and the slave answers with ready/err.
interface clk_divider_prog_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             CFG_VALID;
    logic             CFG_READY;
    logic [CH_W-1:0]  CFG_CH;
    logic [CNT_W-1:0] CFG_DIV;
    logic             CFG_ERR;

    modport master (
        output CFG_VALID,
        output CFG_CH,
        output CFG_DIV,
        input  CFG_READY,
        input  CFG_ERR
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CH,
        input  CFG_DIV,
        output CFG_READY,
        output CFG_ERR
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider with boundary-aligned ratio
// updates, per-channel enable and a global phase-sync restart.
module clk_divider_prog #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 250
) (
    input  logic              INPUT_CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] EN,
    input  logic              SYNC,
    clk_divider_prog_if.slave CFG,
    output logic [NUM_CH-1:0] OUTPUT_CLK,
    output logic [NUM_CH-1:0] TICK
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           st_q   [NUM_CH];
    state_e           st_d   [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [CNT_W-1:0] act_q  [NUM_CH];
    logic [CNT_W-1:0] act_d  [NUM_CH];
    logic [CNT_W-1:0] shd_q  [NUM_CH];
    logic [CNT_W-1:0] shd_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] oclk_q, oclk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              err_q;

    logic cfg_ready;
    logic cfg_fire;
    logic cfg_bad;
    logic cfg_acc;

    // Ready depends only on the addressed channel, never on VALID.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CFG.CFG_CH == CH_W'(i)) cfg_ready = !pend_q[i];
        end
    end

    assign cfg_fire = CFG.CFG_VALID && cfg_ready;
    assign cfg_bad  = (CFG.CFG_DIV < CNT_W'(2)) ||
                      (32'(CFG.CFG_CH) >= NUM_CH);
    assign cfg_acc  = cfg_fire && !cfg_bad;

    assign CFG.CFG_READY = cfg_ready;
    assign CFG.CFG_ERR   = err_q;
    assign OUTPUT_CLK    = oclk_q;
    assign TICK          = tick_q;

    always_comb begin
        logic             acc_i;
        logic [CNT_W-1:0] nxt;
        acc_i  = 1'b0;
        nxt    = '0;
        pend_d = pend_q;
        oclk_d = oclk_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            act_d[i] = act_q[i];
            shd_d[i] = shd_q[i];
            acc_i    = cfg_acc && (CFG.CFG_CH == CH_W'(i));
            nxt      = pend_q[i] ? shd_q[i] : act_q[i];
            if (SYNC && EN[i]) begin
                // A ratio accepted alongside SYNC takes effect immediately.
                if (acc_i) begin
                    nxt      = CFG.CFG_DIV;
                    shd_d[i] = CFG.CFG_DIV;
                end
                act_d[i]  = nxt;
                pend_d[i] = 1'b0;
                st_d[i]   = HIGH;
                cnt_d[i]  = (nxt >> 1) - CNT_W'(1);
                oclk_d[i] = 1'b1;
                tick_d[i] = 1'b1;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        act_d[i]  = nxt;
                        pend_d[i] = 1'b0;
                        oclk_d[i] = 1'b0;
                        if (EN[i]) begin
                            st_d[i]   = HIGH;
                            cnt_d[i]  = (nxt >> 1) - CNT_W'(1);
                            oclk_d[i] = 1'b1;
                            tick_d[i] = 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end else begin
                            st_d[i]   = LOW;
                            oclk_d[i] = 1'b0;
                            cnt_d[i]  = act_q[i] - (act_q[i] >> 1)
                                        - CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end else begin
                            act_d[i]  = nxt;
                            pend_d[i] = 1'b0;
                            if (EN[i]) begin
                                st_d[i]   = HIGH;
                                cnt_d[i]  = (nxt >> 1) - CNT_W'(1);
                                oclk_d[i] = 1'b1;
                                tick_d[i] = 1'b1;
                            end else begin
                                st_d[i] = IDLE;
                            end
                        end
                    end
                    default: begin
                        st_d[i]   = IDLE;
                        oclk_d[i] = 1'b0;
                    end
                endcase
                // Accepted on a boundary: waits for the following one.
                if (acc_i) begin
                    shd_d[i]  = CFG.CFG_DIV;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge INPUT_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
                act_q[i] <= CNT_W'(DEFAULT_DIV);
                shd_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            pend_q <= '0;
            oclk_q <= '0;
            tick_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
            pend_q <= pend_d;
            oclk_q <= oclk_d;
            tick_q <= tick_d;
            err_q  <= cfg_fire && cfg_bad;
        end
    end
endmodule
